// File: rtl/key_nibble_loader.sv
// Serial key loader for the 4-bit NAND latch key bank: shifts nibbles in, presents them, strobes latch-enable.
// Define KEY_PARITY_EN to add a trailing even-parity bit per nibble with sticky error reporting.
module key_nibble_loader #(
  parameter int KEY_NIBBLES = 4,
  parameter int LE_CYCLES   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_ser_bit,
  input  logic       i_ser_valid,
  output logic       o_ser_ready,
  output logic [3:0] o_key_data,
  output logic       o_key_le,
  output logic [3:0] o_key_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_par_err
);

`ifdef KEY_PARITY_EN
  localparam int NBITS = 5;
`else
  localparam int NBITS = 4;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_sreg, w_sreg_nxt;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_le_cnt;
  logic [3:0] r_nib;
  logic       r_ser_ready, r_key_le, r_busy, r_done;
  logic [3:0] r_key_data, r_key_sel;
  logic       w_ready_nxt, w_le_nxt, w_busy_nxt, w_done_nxt;
  logic       w_xfer, w_last, w_start_ok, w_load;

  assign w_xfer     = r_ser_ready & i_ser_valid & (r_state == S_SHIFT);
  assign w_last     = w_xfer & (r_bit_cnt == 3'(NBITS - 1));
  assign w_start_ok = (r_state == S_IDLE) & i_start & ~i_abort;
  // The parity bit is the 5th transfer and is never shifted into the nibble.
  assign w_sreg_nxt = (w_xfer && r_bit_cnt < 3'd4) ? {r_sreg[2:0], i_ser_bit} : r_sreg;

`ifdef KEY_PARITY_EN
  logic w_par_bad;
  logic r_par_err;
  assign w_par_bad = (^r_sreg) != i_ser_bit;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start) w_state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (w_last) begin
`ifdef KEY_PARITY_EN
            w_state_nxt = w_par_bad ? S_IDLE : S_SETUP;
`else
            w_state_nxt = S_SETUP;
`endif
          end
        end
        S_SETUP:  w_state_nxt = S_STROBE;
        S_STROBE: if (r_le_cnt == 4'd0) w_state_nxt = S_HOLD;
        S_HOLD:   w_state_nxt = (r_nib == 4'(KEY_NIBBLES - 1)) ? S_DONE : S_SHIFT;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_ready_nxt = (w_state_nxt == S_SHIFT);
    w_le_nxt    = (w_state_nxt == S_STROBE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_load      = (w_state_nxt == S_SETUP);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg      <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_le_cnt    <= 4'd0;
      r_nib       <= 4'd0;
      r_ser_ready <= 1'b0;
      r_key_le    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_data  <= 4'd0;
      r_key_sel   <= 4'd0;
    end else begin
      r_ser_ready <= w_ready_nxt;
      r_key_le    <= w_le_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;

      if (i_abort || w_start_ok) begin
        r_sreg    <= 4'd0;
        r_bit_cnt <= 3'd0;
      end else if (w_xfer) begin
        r_sreg    <= w_sreg_nxt;
        r_bit_cnt <= w_last ? 3'd0 : r_bit_cnt + 3'd1;
      end

      if (r_state == S_SETUP)
        r_le_cnt <= 4'(LE_CYCLES - 1);
      else if (r_state == S_STROBE && r_le_cnt != 4'd0)
        r_le_cnt <= r_le_cnt - 4'd1;

      if (w_start_ok)
        r_nib <= 4'd0;
      else if (r_state == S_HOLD && w_state_nxt == S_SHIFT)
        r_nib <= r_nib + 4'd1;

      if (w_load) begin
        r_key_data <= w_sreg_nxt;
        r_key_sel  <= r_nib;
      end
    end
  end

`ifdef KEY_PARITY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          r_par_err <= 1'b0;
    else if (w_start_ok)                r_par_err <= 1'b0;
    else if (w_last && w_par_bad && !i_abort) r_par_err <= 1'b1;
  end
  assign o_par_err = r_par_err;
`else
  assign o_par_err = 1'b0;
`endif

  assign o_ser_ready = r_ser_ready;
  assign o_key_data  = r_key_data;
  assign o_key_le    = r_key_le;
  assign o_key_sel   = r_key_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/key_nibble_loader.md
Name: key_nibble_loader

Overview:
- Upstream feeder for the 4-bit NAND latch key bank.
- Accepts a serial locking key over a valid/ready stream and assembles it into 4-bit nibbles.
- Drives each nibble onto the bank's four data inputs, then raises the bank's common latch-enable for a programmable width.
- Sequences all nibbles of the key. Reports busy/done.

Parameters:
- KEY_NIBBLES, 4: number of 4-bit nibbles per key load (total key bits = 4*KEY_NIBBLES); legal 1..16.
- LE_CYCLES, 2: latch-enable high width in clocks; legal 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a key load; sampled only in IDLE.
- abort  input  1  synchronous cancel; highest priority after rst.
- ser_bit  input  1  serial key bit, MSB of each nibble first.
- ser_valid  input  1  ser_bit is valid.
- ser_ready  output  1  loader accepts ser_bit this cycle.
- key_data  output  4  nibble to latch bank data inputs; bit 3 is the first bit received.
- key_le  output  1  latch-enable to bank (bank's shared enable line).
- key_sel  output  4  index of nibble currently presented (0..KEY_NIBBLES-1).
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the final nibble's HOLD completes.
- par_err  output  1  parity error flag (KEY_PARITY_EN only; tied 0 otherwise).

Behaviour:
- Reset values (async, rst high): state=IDLE; key_data=0, key_le=0, key_sel=0, ser_ready=0, busy=0, done=0, par_err=0; shift register, bit count and LE counter cleared.
- All outputs are registered.
- FSM states: IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - ser_ready=0, busy=0.
  - start=1 → SHIFT with nibble index=0, bit count=0. The par_err sticky flag is cleared on this start.
- SHIFT:
  - ser_ready=1, busy=1.
  - Each transfer (ser_valid & ser_ready): sreg <= {sreg[2:0], ser_bit}, bit count +1.
  - ser_valid low stalls indefinitely; no timeout.
  - On the 4th transfer → SETUP; ser_ready drops the cycle after the 4th transfer.
- SETUP (1 cycle):
  - key_data <= sreg and key_sel <= nibble index on entry; key_le=0.
  - Data is therefore stable one full cycle before the enable rises.
- STROBE: key_le=1 for exactly LE_CYCLES cycles, then → HOLD.
- HOLD (1 cycle):
  - key_le=0; key_data unchanged, giving hold time after the enable falls.
  - If nibble index==KEY_NIBBLES-1 → DONE; else nibble index +1, → SHIFT.
- DONE: done=1 for one cycle, busy still 1; then → IDLE.
- Output stability:
  - key_data and key_sel change only on SETUP entry, or on abort/reset.
  - Between loads they retain the last nibble.
- Per-nibble latency: 4 transfer cycles (no stalls) + 1 + LE_CYCLES + 1.
  - Full load at defaults: 4*(4+1+2+1)+1 = 33 cycles from the first SHIFT cycle to the done pulse.
- Boundary and priority cases:
  - start while not IDLE: ignored.
  - start and abort in the same cycle in IDLE: abort wins, stays IDLE.
  - abort in any state: next state IDLE; key_le, ser_ready, busy=0 next cycle. key_data/key_sel hold their values. No done pulse. Partial sreg discarded.
  - abort during STROBE truncates the enable pulse; a partially latched bank is the caller's responsibility.
  - ser_valid in IDLE/SETUP/STROBE/HOLD/DONE: not accepted (ser_ready=0); the source must hold the bit.
  - rst asserted mid-load: immediate return to reset values, independent of clk.
  - Nibble index and key_sel are 4 bits wide; upper bits are zero when KEY_NIBBLES<16.

Optional Feature:
- Macro: KEY_PARITY_EN
- With the macro defined:
  - SHIFT accepts 5 bits per nibble; the 5th is an even-parity bit over the 4 data bits.
  - On mismatch: par_err <= 1 (sticky until the next accepted start), FSM → IDLE with no SETUP/STROBE for that nibble and no done.
  - Earlier nibbles remain latched in the bank.
  - Per-nibble latency rises by 1 cycle.
- Without the macro: 4 bits per nibble, no parity logic, par_err constant 0.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-STROBE.
  - Required response: key_le falls within the same cycle (async); all outputs at reset values; FSM in IDLE after release.
- Nominal load:
  - Stimulus: defaults, key 0xA5C3 streamed with ser_valid held high.
  - Required response: key_data=A,5,C,3 at key_sel=0,1,2,3. Each is stable 1 cycle before key_le rises; key_le high exactly 2 cycles; key_le low ≥1 cycle between nibbles. done pulses once, at cycle 33.
- Stalled stream:
  - Stimulus: ser_valid toggled every other cycle, key 0x0F.
  - Required response: identical key_data sequence. key_le never rises before the 4th bit of each nibble; done is delayed by exactly the number of stall cycles.
- Abort:
  - Stimulus: abort during the 2nd STROBE cycle of nibble 1.
  - Required response: key_le=0 and busy=0 next cycle; key_data holds nibble 1; no done; a new start reloads from key_sel=0.
- Ignored start:
  - Stimulus: start pulsed while busy=1.
  - Required response: no state change; load completes normally.
- Parity (KEY_PARITY_EN):
  - Stimulus: nibble 0xB sent with parity bit 0, which is incorrect.
  - Required response: par_err=1, no key_le pulse, FSM in IDLE. A following start clears par_err, and a correct load completes with done=1.
